toeplitz_seq: RTL

- Sequencer and row generator for the Toeplitz row accumulator (the 3072-bit GF(2) XOR accumulator driven by coefficient words).
- On `start`, loads the initial Toeplitz row from seed memory and enables the accumulator.
- Serves each coefficient-word fetch from coefficient memory and advances the Toeplitz row one bit per accumulate step, refilling from the seed stream.
- Signals completion when the accumulator raises its write strobe.

---
 rtl/toeplitz_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/toeplitz_seq.sv
// Sequencer for the Toeplitz row accumulator: loads the seed row, serves coefficient
// fetches and slides the row one seed bit per accumulate step.
module toeplitz_seq #(
  parameter int ROW_W    = 3072,
  parameter int WORD_W   = 32,
  parameter int N_WORDS  = 128,
  parameter int STEP_CNT = 31,
  parameter int SEED_AW  = 8,
  parameter int COEF_AW  = 7
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               seed_rd_en,
  output logic [SEED_AW-1:0] seed_addr,
  input  logic [WORD_W-1:0]  seed_data,
  output logic               coeff_rd_en,
  output logic [COEF_AW-1:0] coeff_addr,
  output logic               sum_en,
  input  logic               acc_read_en,
  input  logic               acc_write_en,
  output logic [ROW_W-1:0]   shift_row
);
  localparam int L   = ROW_W / WORD_W;
  localparam int LCW = $clog2(L + 2);
  localparam int BCW = $clog2(WORD_W + 1);
  localparam int WCW = $clog2(N_WORDS + 1);
  localparam int SCW = $clog2(STEP_CNT + 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [LCW-1:0]    ld_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [SCW-1:0]    win_cnt;
  logic [WORD_W-1:0] sbuf, snext;
  logic              snext_pend;
  logic              accept, fetch, ld_last, advance, err_set;

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fetch     = 1'b0;
    ld_last   = 1'b0;
    case (state)
      IDLE: if (start) begin accept = 1'b1; state_nxt = LOAD; end
      LOAD: if (ld_cnt == LCW'(L + 1)) begin ld_last = 1'b1; state_nxt = RUN; end
      RUN:  if (acc_write_en) state_nxt = DONE;
            else if (acc_read_en) fetch = 1'b1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first of the STEP_CNT+1 window cycles is the coefficient-memory latency slot.
  assign advance     = (win_cnt != '0) && (win_cnt <= SCW'(STEP_CNT));
  assign coeff_rd_en = fetch;
  assign coeff_addr  = word_cnt[COEF_AW-1:0];
  assign done        = (state == DONE);
  assign err_set     = (fetch && ((win_cnt != '0) || (word_cnt == WCW'(N_WORDS)))) ||
                       (acc_write_en && (state != RUN));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      busy       <= 1'b0;
      err        <= 1'b0;
      sum_en     <= 1'b0;
      seed_rd_en <= 1'b0;
      seed_addr  <= '0;
      shift_row  <= '0;
      ld_cnt     <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      win_cnt    <= '0;
      sbuf       <= '0;
      snext      <= '0;
      snext_pend <= 1'b0;
    end else begin
      seed_rd_en <= 1'b0;
      snext_pend <= seed_rd_en && (state != LOAD);
      if (snext_pend) snext <= seed_data;

      if (accept) err <= 1'b0;
      else if (err_set) err <= 1'b1;

      if (accept) begin
        busy       <= 1'b1;
        seed_rd_en <= 1'b1;
        seed_addr  <= '0;
        ld_cnt     <= '0;
        bit_cnt    <= '0;
        word_cnt   <= '0;
        win_cnt    <= '0;
      end

      if (state == LOAD) begin
        ld_cnt <= ld_cnt + LCW'(1);
        if (ld_cnt < LCW'(L)) begin
          seed_rd_en <= 1'b1;
          seed_addr  <= seed_addr + SEED_AW'(1);
        end
        if (ld_cnt >= LCW'(1) && ld_cnt <= LCW'(L))
          shift_row <= {shift_row[ROW_W-WORD_W-1:0], seed_data};
      end

      // Entering RUN: last load word goes to sbuf, prefetch the following word into snext.
      if (ld_last) begin
        sbuf       <= seed_data;
        sum_en     <= 1'b1;
        seed_rd_en <= 1'b1;
        seed_addr  <= seed_addr + SEED_AW'(1);
      end

      if (state == RUN && acc_write_en) begin
        sum_en <= 1'b0;
        busy   <= 1'b0;
      end

      if (fetch) begin
        word_cnt <= word_cnt + WCW'(1);
        win_cnt  <= SCW'(STEP_CNT + 1);
      end else if (win_cnt != '0) begin
        win_cnt <= win_cnt - SCW'(1);
      end

      if (advance) begin
        shift_row <= {shift_row[ROW_W-2:0], sbuf[WORD_W-1]};
        if (bit_cnt == BCW'(WORD_W - 1)) begin
          sbuf       <= snext;
          bit_cnt    <= '0;
          seed_rd_en <= 1'b1;
          seed_addr  <= seed_addr + SEED_AW'(1);
        end else begin
          sbuf    <= sbuf << 1;
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end
    end
  end
endmodule
